alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Two-stage pipelined front end for the combinational 32-bit ALU. It accepts ALU commands over a valid/ready handshake and registers them into an issue stage that drives the ALU inputs directly. On the next edge it captures the ALU result and overflow into an output stage that has its own valid/ready handshake. It sits between the instruction decode logic upstream and the ALU, and also maintains a sticky overflow flag and a completed-operation counter.

## Interface
- TAG_W, 4, width of the opaque tag carried with each command
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  command present on in_op/in_src1/in_src2/in_tag
- in_ready  out  1  stage can accept a command this cycle
- in_op  in  5  ALU opcode (ALU encoding)
- in_src1, in_src2  in  32  operands
- in_tag  in  TAG_W  tag returned with the result
- alu_enable  out  1  to ALU; high only for a legal op held in the issue stage
- alu_op  out  5  to ALU
- alu_src1, alu_src2  out  32  to ALU
- alu_result  in  32  from ALU (combinational)
- alu_ovf  in  1  from ALU
- out_valid  out  1  result held in the output stage
- out_ready  in  1  downstream accepts the result
- out_data  out  32  result
- out_ovf  out  1  overflow for this result
- out_err  out  1  opcode was illegal
- out_tag  out  TAG_W  tag of this result
- ovf_sticky  out  1  set by any captured result with out_ovf=1
- clr_sticky  in  1  synchronous clear of ovf_sticky
- op_count  out  CNT_W  number of results consumed downstream

## Operation
- Legal opcodes are 5'h00 to 5'h0C (ADD, SUB, AND, OR, XOR, NOR, SRL, ROTR, NOT, NAND, MAX, MIN, ABS). All other codes (5'h0D to 5'h1F) are illegal.
- **Issue stage (A):** registers a_valid, op, src1, src2, tag and an illegal bit computed at accept.
  - alu_op, alu_src1 and alu_src2 come from A registers with no logic in between.
  - alu_enable = a_valid & ~a_illegal.
- **Output stage (B):** registers b_valid, data, ovf, err, tag.
  - On capture: data=alu_result, ovf=alu_ovf, err=0.
  - If the op was illegal: data=0, ovf=0, err=1.
- **Flow control:**
  - advance = a_valid & (~b_valid | out_ready)
  - in_ready = ~a_valid | advance
  - Accept when in_valid & in_ready.
  - A is loaded on accept. Otherwise A is cleared when advance is true.
  - B is loaded when advance is true. Otherwise b_valid is cleared on out_ready.
- Results leave strictly in acceptance order. There is no internal reordering or dropping.
- in_ready depends combinationally on out_ready. No other combinational input-to-output path exists except through the ALU.
- **ovf_sticky:** set when B loads a result with ovf=1. Cleared by clr_sticky. If set and clear happen in the same cycle, set wins.
- **op_count:** increments on out_valid & out_ready. Wraps from all-ones to 0 with no flag.

## Timing
- **Reset (asynchronous, immediate):**
  - a_valid=0, b_valid=0, ovf_sticky=0, op_count=0.
  - All data, tag, ovf and err registers are 0.
  - Outputs: in_ready=1, out_valid=0, alu_enable=0.
- **Latency:** a command accepted at edge t is presented with out_valid=1 after edge t+1.
- **Throughput:** one command per cycle while out_ready=1.
- **Full condition:** both stages valid and out_ready=0. In that state in_ready=0 and all state holds. At most 2 commands are in flight.
- **Simultaneous events:**
  - Accept while B drains and A advances in the same cycle: all three take effect.
  - Accept into an empty A while B is stalled is allowed (A was empty).
- **Output stability:** while out_valid=1 and out_ready=0, out_data, out_ovf, out_err and out_tag stay stable.
- **Reset mid-operation:** all in-flight commands are discarded. No out_valid pulse appears after rst_n is released until a new command is accepted.

## Test plan
- **Single ADD:** op=5'h00, src1=32'h7FFF_FFFF, src2=1, tag=3.
  - After 2 edges: out_valid=1, out_data=32'h8000_0000, out_ovf=1, out_tag=3.
  - ovf_sticky=1 in the following cycle.
  - clr_sticky pulse returns it to 0.
- **Streaming:** 8 back-to-back SUBs with out_ready=1.
  - in_ready stays 1.
  - Results appear on 8 consecutive cycles in tag order 0..7.
  - op_count=8.
- **Backpressure:** out_ready=0 while sending 3 commands.
  - 2 are accepted, then in_ready=0.
  - Raising out_ready drains the results in order. The third is accepted in the same cycle B drains.
- **Illegal op:** op=5'h10.
  - alu_enable stays 0 throughout.
  - Result: out_err=1, out_data=0, out_ovf=0, ovf_sticky unchanged.
- **Sticky priority and counter wrap:**
  - Overflowing ABS (src1=32'h8000_0000) captured in the same cycle as clr_sticky=1 gives ovf_sticky=1.
  - With op_count preloaded to 16'hFFFF by streaming, one more consumed result gives 0.
- **Reset mid-flight:** drop rst_n with A and B both valid and out_ready=0.
  - Immediately: out_valid=0, in_ready=1, op_count=0.
  - After release: no stray result appears.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Command and result handshake bundle for the ALU issue stage.
// master drives commands and accepts results; slave is the stage.
interface alu_issue_stage_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_ovf;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag,
    input  in_ready,
    input  out_valid, out_data, out_ovf, out_err, out_tag,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag,
    output in_ready,
    output out_valid, out_data, out_ovf, out_err, out_tag,
    input  out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage front end for the combinational ALU: issue register A
// drives the ALU, output register B captures its result.
module alu_issue_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus,
  output logic               alu_enable,
  output logic [4:0]         alu_op,
  output logic [31:0]        alu_src1,
  output logic [31:0]        alu_src2,
  input  logic [31:0]        alu_result,
  input  logic               alu_ovf,
  output logic               ovf_sticky,
  input  logic               clr_sticky,
  output logic [CNT_W-1:0]   op_count
);
  localparam logic [4:0] OP_LAST = 5'h0C;

  typedef struct packed {
    logic [4:0]       op;
    logic [31:0]      src1;
    logic [31:0]      src2;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } iss_t;

  typedef struct packed {
    logic [31:0]      data;
    logic             ovf;
    logic             err;
    logic [TAG_W-1:0] tag;
  } res_t;

  iss_t a_q, a_d;
  res_t b_q, b_d;
  logic a_valid, b_valid;
  logic advance, accept, consume;

  assign advance  = a_valid & (~b_valid | bus.out_ready);
  assign bus.in_ready = ~a_valid | advance;
  assign accept   = bus.in_valid & bus.in_ready;
  assign consume  = b_valid & bus.out_ready;

  assign a_d.op      = bus.in_op;
  assign a_d.src1    = bus.in_src1;
  assign a_d.src2    = bus.in_src2;
  assign a_d.tag     = bus.in_tag;
  assign a_d.illegal = bus.in_op > OP_LAST;

  assign alu_op     = a_q.op;
  assign alu_src1   = a_q.src1;
  assign alu_src2   = a_q.src2;
  assign alu_enable = a_valid & ~a_q.illegal;

  // Illegal ops never reach the ALU, so its outputs are ignored.
  always_comb begin
    b_d     = '0;
    b_d.tag = a_q.tag;
    unique case (1'b1)
      a_q.illegal: b_d.err = 1'b1;
      default: begin
        b_d.data = alu_result;
        b_d.ovf  = alu_ovf;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_q     <= a_d;
    end else if (advance) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_q     <= '0;
    end else if (advance) begin
      b_valid <= 1'b1;
      b_q     <= b_d;
    end else if (bus.out_ready) begin
      b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (advance & b_d.ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (consume) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = b_valid;
  assign bus.out_data  = b_q.data;
  assign bus.out_ovf   = b_q.ovf;
  assign bus.out_err   = b_q.err;
  assign bus.out_tag   = b_q.tag;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: ALU stub, result scoreboard,
// vector table and hand-written flow-control sequences.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_enable;
  logic [4:0]  alu_op;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        alu_ovf;
  logic        ovf_sticky;
  logic        clr_sticky = 1'b0;
  logic [15:0] op_count;

  alu_issue_stage_if #(.TAG_W(4)) bus ();

  alu_issue_stage #(.TAG_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_enable (alu_enable),
    .alu_op     (alu_op),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_result (alu_result),
    .alu_ovf    (alu_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  tag;
    logic [31:0] d;
    logic        ovf;
    logic        err;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   run = 0;
  int   max_run = 0;
  logic stall_prev = 1'b0;
  exp_t prev;

  function automatic logic [32:0] alu_f(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    logic [63:0] w;
    r = '0;
    v = 1'b0;
    w = {a, a} >> b[4:0];
    case (op)
      5'h00: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'h01: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'h02: r = a & b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = ~(a | b);
      5'h06: r = a >> b[4:0];
      5'h07: r = w[31:0];
      5'h08: r = ~a;
      5'h09: r = ~(a & b);
      5'h0A: r = ($signed(a) > $signed(b)) ? a : b;
      5'h0B: r = ($signed(a) < $signed(b)) ? a : b;
      5'h0C: begin r = a[31] ? -a : a; v = (a == 32'h8000_0000); end
      default: begin r = 32'hDEAD_BEEF; v = 1'b1; end
    endcase
    return {v, r};
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] tag);
    logic [32:0] f;
    exp_t e;
    f = alu_f(op, a, b);
    e.tag = tag;
    if (op > 5'h0C) begin
      e.data = '0; e.ovf = 1'b0; e.err = 1'b1;
    end else begin
      e.data = f[31:0]; e.ovf = f[32]; e.err = 1'b0;
    end
    return e;
  endfunction

  always_comb begin
    {alu_ovf, alu_result} = alu_f(alu_op, alu_src1, alu_src2);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard, output-hold check and valid-run length, sampled at negedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
      run = 0;
    end else begin
      if (stall_prev && bus.out_valid) begin
        chk("hold_data", bus.out_data, prev.data);
        chk("hold_ovf", 32'(bus.out_ovf), 32'(prev.ovf));
        chk("hold_err", 32'(bus.out_err), 32'(prev.err));
        chk("hold_tag", 32'(bus.out_tag), 32'(prev.tag));
      end
      run = bus.out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'(bus.out_tag), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", bus.out_data, e.data);
          chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
          chk("out_err", 32'(bus.out_err), 32'(e.err));
          chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev = '{bus.out_data, bus.out_ovf, bus.out_err, bus.out_tag};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag,
                      input exp_t e, output int waited);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_tag   = tag;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("send_timeout", 32'(waited), 32'd0);
    else q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    idle();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
  endtask

  vec_t tbl[16];
  int   w;

  initial begin
    tbl[0]  = '{5'h00, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b1, 1'b0};
    tbl[1]  = '{5'h01, 32'h0000_0005, 32'h0000_0007, 4'd1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[2]  = '{5'h02, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, 32'hF000_F000, 1'b0, 1'b0};
    tbl[3]  = '{5'h03, 32'h0F0F_0000, 32'h0000_00F0, 4'd4, 32'h0F0F_00F0, 1'b0, 1'b0};
    tbl[4]  = '{5'h04, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 4'd5, 32'h5555_5555, 1'b0, 1'b0};
    tbl[5]  = '{5'h05, 32'h0000_0000, 32'h0000_0000, 4'd6, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[6]  = '{5'h06, 32'h8000_0000, 32'h0000_0004, 4'd7, 32'h0800_0000, 1'b0, 1'b0};
    tbl[7]  = '{5'h07, 32'h0000_0001, 32'h0000_0001, 4'd8, 32'h8000_0000, 1'b0, 1'b0};
    tbl[8]  = '{5'h08, 32'h0000_FFFF, 32'h0000_0000, 4'd9, 32'hFFFF_0000, 1'b0, 1'b0};
    tbl[9]  = '{5'h09, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'h0000_0000, 1'b0, 1'b0};
    tbl[10] = '{5'h0A, 32'hFFFF_FFFF, 32'h0000_0002, 4'd11, 32'h0000_0002, 1'b0, 1'b0};
    tbl[11] = '{5'h0B, 32'hFFFF_FFFF, 32'h0000_0002, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[12] = '{5'h0C, 32'hFFFF_FFFB, 32'h0000_0000, 4'd13, 32'h0000_0005, 1'b0, 1'b0};
    tbl[13] = '{5'h01, 32'h8000_0000, 32'h0000_0001, 4'd14, 32'h7FFF_FFFF, 1'b1, 1'b0};
    tbl[14] = '{5'h10, 32'h1234_5678, 32'h0000_0001, 4'd15, 32'h0000_0000, 1'b0, 1'b1};
    tbl[15] = '{5'h0D, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 4'd0, 32'h0000_0000, 1'b0, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_enable", 32'(alu_enable), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    do_reset();

    // Single ADD with overflow, latency and sticky set/clear
    send(5'h00, 32'h7FFF_FFFF, 32'd1, 4'd3, '{32'h8000_0000, 1'b1, 1'b0, 4'd3}, w);
    idle();
    @(negedge clk);
    chk("add_alu_enable", 32'(alu_enable), 32'd1);
    chk("add_alu_op", 32'(alu_op), 32'd0);
    chk("add_alu_src1", alu_src1, 32'h7FFF_FFFF);
    chk("add_alu_src2", alu_src2, 32'd1);
    chk("add_early_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk("add_sticky_set", 32'(ovf_sticky), 32'd1);
    @(posedge clk);
    #1;
    clr_pulse();
    @(negedge clk);
    chk("add_sticky_clr", 32'(ovf_sticky), 32'd0);
    @(posedge clk);
    #1;

    // Vector table, one command at a time
    foreach (tbl[i]) begin
      clr_pulse();
      send(tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].tag,
           '{tbl[i].d, tbl[i].ovf, tbl[i].err, tbl[i].tag}, w);
      idle();
      @(negedge clk);
      chk($sformatf("vec%0d_alu_enable", i), 32'(alu_enable), 32'(!tbl[i].err));
      drain();
      chk($sformatf("vec%0d_sticky", i), 32'(ovf_sticky), 32'(tbl[i].ovf));
    end

    // Streaming 8 SUBs
    do_reset();
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      send(5'h01, 32'(i * 100), 32'(i * 7 + 1), 4'(i),
           model(5'h01, 32'(i * 100), 32'(i * 7 + 1), 4'(i)), w);
      chk("stream_in_ready", 32'(w), 32'd0);
    end
    idle();
    drain();
    chk("stream_run", 32'(max_run), 32'd8);
    chk("stream_op_count", 32'(op_count), 32'd8);

    // Backpressure: two accepted, third waits, accepted as B drains
    bus.out_ready = 1'b0;
    send(5'h02, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd1, model(5'h02, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'd1), w);
    send(5'h03, 32'h1000_0000, 32'h0000_0001, 4'd2, model(5'h03, 32'h1000_0000, 32'h0000_0001, 4'd2), w);
    chk("bp_second_wait", 32'(w), 32'd0);
    bus.in_op = 5'h04;
    bus.in_src1 = 32'h1111_1111;
    bus.in_src2 = 32'h2222_2222;
    bus.in_tag = 4'd3;
    repeat (3) begin
      @(negedge clk);
      chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_full_tag", 32'(bus.out_tag), 32'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(5'h04, 32'h1111_1111, 32'h2222_2222, 4'd3, model(5'h04, 32'h1111_1111, 32'h2222_2222, 4'd3), w);
    chk("bp_third_same_cycle", 32'(w), 32'd0);
    idle();
    drain();
    chk("bp_op_count", 32'(op_count), 32'd11);

    // Sticky set wins over simultaneous clear
    clr_pulse();
    chk("prio_pre", 32'(ovf_sticky), 32'd0);
    send(5'h0C, 32'h8000_0000, 32'd0, 4'd9, '{32'h8000_0000, 1'b1, 1'b0, 4'd9}, w);
    idle();
    clr_sticky = 1'b1;
    @(posedge clk);
    #1 clr_sticky = 1'b0;
    chk("prio_sticky", 32'(ovf_sticky), 32'd1);
    drain();

    // Reset with both stages full
    bus.out_ready = 1'b0;
    send(5'h00, 32'd1, 32'd2, 4'd4, model(5'h00, 32'd1, 32'd2, 4'd4), w);
    send(5'h00, 32'd3, 32'd4, 4'd5, model(5'h00, 32'd3, 32'd4, 4'd5), w);
    idle();
    @(negedge clk);
    chk("mid_full", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_op_count", 32'(op_count), 32'd0);
    chk("mid_sticky", 32'(ovf_sticky), 32'd0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("mid_no_stray", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      send(5'h08, 32'(i), 32'd0, 4'(i), model(5'h08, 32'(i), 32'd0, 4'(i)), w);
    end
    idle();
    drain();
    chk("wrap_full", 32'(op_count), 32'h0000_FFFF);
    send(5'h02, 32'hABCD_1234, 32'hFFFF_0000, 4'd6, model(5'h02, 32'hABCD_1234, 32'hFFFF_0000, 4'd6), w);
    idle();
    drain();
    chk("wrap_zero", 32'(op_count), 32'd0);
    chk("end_queue_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
